// File: rtl/zuzhen_pkg.sv
// Shared types and helpers for the zuzhen serial frame assembler.
package zuzhen_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCK   = 2'd2
    } zuzhen_state_e;

    localparam logic [15:0] DEFAULT_SYNC = 16'hEB90;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/zuzhen_if.sv
// Serial-in / word-out bundle between the bit source and the frame assembler.
interface zuzhen_if import zuzhen_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int IDX_W = idx_width(32)
);
    logic             din;
    logic             din_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             frame_start;
    logic [IDX_W-1:0] word_idx;
    logic             locked;
    logic             sync_err;

    modport master (
        output din, din_valid,
        input  dout, dout_valid, frame_start, word_idx, locked, sync_err
    );

    modport slave (
        input  din, din_valid,
        output dout, dout_valid, frame_start, word_idx, locked, sync_err
    );
endinterface

// File: rtl/zuzhen_shifter.sv
// LSB-first shift register with bit counter; exposes the look-ahead word and word-complete strobe.
module zuzhen_shifter import zuzhen_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_din,
    input  logic             i_din_valid,
    input  logic             i_bit_clr,
    output logic [WIDTH-1:0] o_nxt,
    output logic             o_word_done
);
    localparam int BW = idx_width(WIDTH);

    logic [WIDTH-1:0] r_shreg;
    logic [BW-1:0]    r_bit_cnt;

    assign o_nxt       = {i_din, r_shreg[WIDTH-1:1]};
    assign o_word_done = i_din_valid && (r_bit_cnt == BW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (i_din_valid) begin
            r_shreg <= o_nxt;
            // A sync hit marks the current bit as the last bit of word 0.
            if (i_bit_clr || o_word_done)
                r_bit_cnt <= '0;
            else
                r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/zuzhen_frame.sv
// Frame assembler: sync hunt, multi-frame confirmation and flywheel lock.
// Optional polarity correction when ZUZHEN_SYNC_INV_EN is defined.
//
// state  | meaning
// HUNT   | sliding compare of every bit window against the sync word
// VERIFY | sync found, counting frames until CONFIRM_N hits in a row
// LOCK   | aligned, emitting every word; MISS_MAX sync misses drop to HUNT
module zuzhen_frame import zuzhen_pkg::*; #(
    parameter int               WIDTH       = 16,
    parameter int               FRAME_WORDS = 32,
    parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(DEFAULT_SYNC),
    parameter int               CONFIRM_N   = 2,
    parameter int               MISS_MAX    = 3
) (
    input  logic     clk,
    input  logic     reset,
    zuzhen_if.slave  bus
);
    localparam int IDX_W  = idx_width(FRAME_WORDS);
    localparam int HIT_W  = idx_width(CONFIRM_N + 1);
    localparam int MISS_W = idx_width(MISS_MAX + 1);

    localparam logic [1:0] S_HUNT   = ST_HUNT;
    localparam logic [1:0] S_VERIFY = ST_VERIFY;
    localparam logic [1:0] S_LOCK   = ST_LOCK;

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_word_cnt;
    logic [HIT_W-1:0]  r_hit_cnt;
    logic [MISS_W-1:0] r_miss_cnt;
    logic [WIDTH-1:0]  r_dout;
    logic              r_dout_valid;
    logic              r_frame_start;
    logic [IDX_W-1:0]  r_word_idx;
    logic              r_sync_err;

    logic [WIDTH-1:0]  w_nxt;
    logic              w_word_done;
    logic              w_hunt_pos;
    logic              w_hunt_neg;
    logic              w_hunt_hit;
    logic              w_inv;
    logic              w_hit;
    logic [WIDTH-1:0]  w_word_out;
    logic [IDX_W-1:0]  w_word_cnt_nx;
    logic [HIT_W-1:0]  w_hit_inc;
    logic [MISS_W-1:0] w_miss_inc;

    zuzhen_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .i_din       (bus.din),
        .i_din_valid (bus.din_valid),
        .i_bit_clr   (w_hunt_hit && (r_state == S_HUNT)),
        .o_nxt       (w_nxt),
        .o_word_done (w_word_done)
    );

    assign w_hunt_pos = (w_nxt == SYNC_WORD);

`ifdef ZUZHEN_SYNC_INV_EN
    logic r_inv;

    assign w_hunt_neg = (w_nxt == ~SYNC_WORD);
    assign w_inv      = r_inv;

    always_ff @(posedge clk) begin
        if (reset)
            r_inv <= 1'b0;
        else if (bus.din_valid && (r_state == S_HUNT) && w_hunt_hit)
            r_inv <= w_hunt_neg;
    end
`else
    assign w_hunt_neg = 1'b0;
    assign w_inv      = 1'b0;
`endif

    assign w_hunt_hit    = w_hunt_pos || w_hunt_neg;
    assign w_hit         = (w_nxt == (w_inv ? ~SYNC_WORD : SYNC_WORD));
    assign w_word_out    = w_inv ? ~w_nxt : w_nxt;
    assign w_word_cnt_nx = (r_word_cnt == IDX_W'(FRAME_WORDS - 1)) ? '0 : r_word_cnt + 1'b1;
    assign w_hit_inc     = r_hit_cnt + 1'b1;
    assign w_miss_inc    = r_miss_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_HUNT;
            r_word_cnt    <= '0;
            r_hit_cnt     <= '0;
            r_miss_cnt    <= '0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_word_idx    <= '0;
            r_sync_err    <= 1'b0;
        end else begin
            r_dout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_sync_err    <= 1'b0;
            if (bus.din_valid) begin
                case (r_state)
                    S_HUNT: begin
                        if (w_hunt_hit) begin
                            r_word_cnt <= IDX_W'(1);
                            r_hit_cnt  <= HIT_W'(1);
                            r_miss_cnt <= '0;
                            r_state    <= (CONFIRM_N == 1) ? S_LOCK : S_VERIFY;
                        end
                    end
                    S_VERIFY: begin
                        if (w_word_done) begin
                            r_word_cnt <= w_word_cnt_nx;
                            if (r_word_cnt == '0) begin
                                if (w_hit) begin
                                    r_hit_cnt <= w_hit_inc;
                                    if (w_hit_inc == HIT_W'(CONFIRM_N)) begin
                                        r_state       <= S_LOCK;
                                        r_dout        <= w_word_out;
                                        r_dout_valid  <= 1'b1;
                                        r_frame_start <= 1'b1;
                                        r_word_idx    <= '0;
                                    end
                                end else begin
                                    r_state   <= S_HUNT;
                                    r_hit_cnt <= '0;
                                end
                            end
                        end
                    end
                    S_LOCK: begin
                        if (w_word_done) begin
                            r_word_cnt <= w_word_cnt_nx;
                            if ((r_word_cnt == '0) && !w_hit) begin
                                r_sync_err <= 1'b1;
                                if (w_miss_inc == MISS_W'(MISS_MAX)) begin
                                    r_state    <= S_HUNT;
                                    r_miss_cnt <= '0;
                                    r_hit_cnt  <= '0;
                                end else begin
                                    // Flywheel: keep the frame timing and still deliver the slot.
                                    r_miss_cnt    <= w_miss_inc;
                                    r_dout        <= w_word_out;
                                    r_dout_valid  <= 1'b1;
                                    r_frame_start <= 1'b1;
                                    r_word_idx    <= r_word_cnt;
                                end
                            end else begin
                                if (r_word_cnt == '0)
                                    r_miss_cnt <= '0;
                                r_dout        <= w_word_out;
                                r_dout_valid  <= 1'b1;
                                r_frame_start <= (r_word_cnt == '0);
                                r_word_idx    <= r_word_cnt;
                            end
                        end
                    end
                    default: r_state <= S_HUNT;
                endcase
            end
        end
    end

    assign bus.dout        = r_dout;
    assign bus.dout_valid  = r_dout_valid;
    assign bus.frame_start = r_frame_start;
    assign bus.word_idx    = r_word_idx;
    assign bus.sync_err    = r_sync_err;
    assign bus.locked      = (r_state == S_LOCK);
endmodule

// File: tb/tb_zuzhen_frame.sv
// Self-checking bench for zuzhen_frame: frame-level table plus positional reference model.
`timescale 1ns/1ps
module tb_zuzhen_frame;
    import zuzhen_pkg::*;

    localparam int W     = 16;
    localparam int FW    = 32;
    localparam int FL    = W * FW;
    localparam int CONF  = 2;
    localparam int MISS  = 3;
    localparam int IDX_W = idx_width(FW);
    localparam logic [W-1:0] SYNC = 16'hEB90;
`ifdef ZUZHEN_SYNC_INV_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    typedef struct {
        logic [W-1:0]     dout;
        logic             fs;
        logic [IDX_W-1:0] idx;
        logic             err;
        logic             valid;
        logic             locked;
    } ev_t;

    typedef struct {
        logic [W-1:0] sync_tx;
        int           n_valid;
        int           n_fs;
        int           n_err;
        logic         locked_end;
    } row_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    bit   stream_q[$];
    ev_t  act_q[$];
    ev_t  exp_q[$];
    row_t tbl[10];

    always #5 clk = ~clk;

    zuzhen_if #(.WIDTH(W), .IDX_W(IDX_W)) bus ();

    zuzhen_frame #(
        .WIDTH(W), .FRAME_WORDS(FW), .SYNC_WORD(SYNC), .CONFIRM_N(CONF), .MISS_MAX(MISS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(negedge clk)
        if (!reset && (bus.dout_valid || bus.sync_err))
            act_q.push_back('{bus.dout, bus.frame_start, bus.word_idx, bus.sync_err,
                              bus.dout_valid, bus.locked});

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) stream_q.push_back(w[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.din_valid = 1'b0;
        end
    endtask

    task automatic send_stream(input int gap_pct);
        foreach (stream_q[i]) begin
            for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
                @(negedge clk);
                bus.din_valid = 1'b0;
            end
            @(negedge clk);
            bus.din       = stream_q[i];
            bus.din_valid = 1'b1;
        end
        idle(4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.din       = 1'($urandom);
            bus.din_valid = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        bus.din_valid = 1'b0;
        act_q.delete();
    endtask

    // Window of W bits ending at stream position e, first bit at LSB; bits before the stream read as 0.
    function automatic logic [W-1:0] win(input int e);
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++)
            if (e - W + 1 + i >= 0) w[i] = stream_q[e - W + 1 + i];
        return w;
    endfunction

    // Reference model: sync positions are found by sliding search, then frames are stepped by FL bits.
    task automatic run_model();
        int n = stream_q.size();
        int p = 0;
        int q;
        int e;
        int miss;
        bit inv;
        bit ok;
        logic [W-1:0] w;
        logic [W-1:0] ref_w;
        logic [W-1:0] mask;
        exp_q.delete();
        while (p < n) begin
            w = win(p);
            if (w == SYNC || (INV && w == ~SYNC)) begin
                inv   = (w != SYNC);
                ref_w = inv ? ~SYNC : SYNC;
                mask  = {W{inv}};
                ok    = 1'b1;
                q     = p;
                for (int k = 1; k < CONF; k++) begin
                    q = p + k * FL;
                    if (q >= n) return;
                    if (win(q) != ref_w) begin
                        ok = 1'b0;
                        break;
                    end
                end
                if (!ok) begin
                    p = q + 1;
                    continue;
                end
                if (CONF > 1) exp_q.push_back('{win(q) ^ mask, 1'b1, '0, 1'b0, 1'b1, 1'b1});
                miss = 0;
                while (1) begin
                    for (int j = 1; j < FW; j++) begin
                        e = q + j * W;
                        if (e >= n) return;
                        exp_q.push_back('{win(e) ^ mask, 1'b0, IDX_W'(j), 1'b0, 1'b1, 1'b1});
                    end
                    q = q + FL;
                    if (q >= n) return;
                    w = win(q);
                    if (w == ref_w) begin
                        miss = 0;
                        exp_q.push_back('{w ^ mask, 1'b1, '0, 1'b0, 1'b1, 1'b1});
                    end else begin
                        miss++;
                        if (miss == MISS) begin
                            exp_q.push_back('{'0, 1'b0, '0, 1'b1, 1'b0, 1'b0});
                            break;
                        end
                        exp_q.push_back('{w ^ mask, 1'b1, '0, 1'b1, 1'b1, 1'b1});
                    end
                end
                p = q + 1;
            end else begin
                p++;
            end
        end
    endtask

    task automatic compare_events(input string nm);
        int n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        chk({nm, " event count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s ev%0d valid", nm, i), act_q[i].valid, exp_q[i].valid);
            chk($sformatf("%s ev%0d sync_err", nm, i), act_q[i].err, exp_q[i].err);
            chk($sformatf("%s ev%0d locked", nm, i), act_q[i].locked, exp_q[i].locked);
            if (exp_q[i].valid) begin
                chk($sformatf("%s ev%0d dout", nm, i), act_q[i].dout, exp_q[i].dout);
                chk($sformatf("%s ev%0d frame_start", nm, i), act_q[i].fs, exp_q[i].fs);
                chk($sformatf("%s ev%0d word_idx", nm, i), act_q[i].idx, exp_q[i].idx);
            end
        end
    endtask

    task automatic run_case(input string nm, input int gap_pct);
        act_q.delete();
        run_model();
        send_stream(gap_pct);
        compare_events(nm);
    endtask

    task automatic build_counting_stream(input int n_frames, input bit invert);
        stream_q.delete();
        for (int i = 0; i < 7; i++) stream_q.push_back(1'($urandom));
        for (int f = 0; f < n_frames; f++)
            for (int j = 0; j < FW; j++)
                add_word((j == 0 ? SYNC : W'(j)) ^ {W{invert}});
    endtask

    task automatic check_acq(input string nm);
        chk({nm, " enough words"}, 32'(act_q.size() >= 32), 1);
        if (act_q.size() >= 32) begin
            chk({nm, " first dout"}, act_q[0].dout, SYNC);
            chk({nm, " first frame_start"}, act_q[0].fs, 1);
            chk({nm, " first locked"}, act_q[0].locked, 1);
            chk({nm, " word1 dout"}, act_q[1].dout, 1);
            chk({nm, " word31 idx"}, act_q[31].idx, 31);
            chk({nm, " word31 dout"}, act_q[31].dout, 31);
        end
    endtask

    initial begin
        int nv, nfs, ne, bad;
        logic [W-1:0] xw;

        tbl[0] = '{16'hEB90, 0,  0, 0, 1'b0};
        tbl[1] = '{16'hEB90, 32, 1, 0, 1'b1};
        tbl[2] = '{16'h0000, 32, 1, 1, 1'b1};
        tbl[3] = '{16'h0000, 32, 1, 1, 1'b1};
        tbl[4] = '{16'hEB90, 32, 1, 0, 1'b1};
        tbl[5] = '{16'h0000, 32, 1, 1, 1'b1};
        tbl[6] = '{16'h0000, 32, 1, 1, 1'b1};
        tbl[7] = '{16'h0000, 0,  0, 1, 1'b0};
        tbl[8] = '{16'hEB90, 0,  0, 0, 1'b0};
        tbl[9] = '{16'hEB90, 32, 1, 0, 1'b1};

        bus.din = 1'b0;
        bus.din_valid = 1'b0;
        do_reset();

        stream_q.delete();
        for (int i = 0; i < 7; i++) stream_q.push_back(1'b0);
        send_stream(0);
        for (int r = 0; r < 10; r++) begin
            act_q.delete();
            stream_q.delete();
            for (int j = 0; j < FW; j++) add_word(j == 0 ? tbl[r].sync_tx : W'(j));
            send_stream(0);
            nv = 0; nfs = 0; ne = 0; bad = 0;
            foreach (act_q[i]) begin
                if (act_q[i].valid) begin
                    nv++;
                    if (act_q[i].fs) nfs++;
                    xw = (act_q[i].idx == '0) ? tbl[r].sync_tx : W'(act_q[i].idx);
                    if (act_q[i].dout !== xw) bad++;
                end
                if (act_q[i].err) ne++;
            end
            chk($sformatf("row%0d dout_valid count", r), nv, tbl[r].n_valid);
            chk($sformatf("row%0d frame_start count", r), nfs, tbl[r].n_fs);
            chk($sformatf("row%0d sync_err count", r), ne, tbl[r].n_err);
            chk($sformatf("row%0d locked", r), bus.locked, tbl[r].locked_end);
            chk($sformatf("row%0d bad words", r), bad, 0);
        end

        // Reset while locked and mid-word.
        stream_q.delete();
        for (int i = 0; i < 100; i++) stream_q.push_back(1'($urandom));
        send_stream(0);
        chk("pre-reset locked", bus.locked, 1);
        @(negedge clk);
        reset = 1'b1;
        bus.din = 1'b1;
        bus.din_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset dout", bus.dout, 0);
        chk("reset dout_valid", bus.dout_valid, 0);
        chk("reset frame_start", bus.frame_start, 0);
        chk("reset word_idx", bus.word_idx, 0);
        chk("reset locked", bus.locked, 0);
        chk("reset sync_err", bus.sync_err, 0);
        reset = 1'b0;
        bus.din_valid = 1'b0;
        act_q.delete();

        build_counting_stream(6, 1'b0);
        run_case("acq", 0);
        check_acq("acq");

        do_reset();
        run_case("gapped", 50);
        check_acq("gapped");

        for (int it = 0; it < 3; it++) begin
            do_reset();
            stream_q.delete();
            for (int i = 0; i < 7; i++) stream_q.push_back(1'($urandom));
            for (int f = 0; f < 8; f++) begin
                add_word(($urandom_range(9) < 3) ? W'($urandom) : SYNC);
                for (int j = 1; j < FW; j++)
                    add_word((it == 0) ? W'(j) : W'($urandom));
            end
            run_case($sformatf("rand%0d", it), (it == 2) ? 30 : 0);
        end

`ifdef ZUZHEN_SYNC_INV_EN
        do_reset();
        build_counting_stream(4, 1'b1);
        run_case("inverted", 0);
        check_acq("inverted");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
